t_edge_counter: RTL and testbench

Receiving end of the toggle source `T`: samples that block's `out` toggle signal as an input, synchronises it into this block's clock domain, detects its edges and counts them. It produces a one-cycle edge strobe, a running count, a compare match and a sticky overflow flag for downstream control logic. It is the consumer that the toggle generator feeds with "one edge per event".

---
 rtl/t_edge_counter.sv | 106 ++++++++++
 tb/tb_t_edge_counter.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/t_edge_counter.sv
// rtl/t_edge_counter.sv - toggle-input synchroniser, edge detector and edge counter
//
// Ports:
//   clock      system clock, rising edge
//   reset      asynchronous active-low reset, clears all state
//   t_in       toggle input, may be asynchronous to clock
//   enable     1 = detected edges advance the count
//   clear      synchronous clear of count and overflow
//   mode       00 rising, 01 falling, 10 both, 11 detection off
//   compare    match value for count
//   edge_pulse one-cycle strobe per detected edge
//   count      running edge count
//   match      high while count == compare
//   overflow   sticky, set when a counted edge arrives at max count

module t_edge_counter #(
    parameter int WIDTH    = 8,
    parameter int SATURATE = 0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             t_in,
    input  logic             enable,
    input  logic             clear,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] compare,
    output logic             edge_pulse,
    output logic [WIDTH-1:0] count,
    output logic             match,
    output logic             overflow
);

    localparam logic [WIDTH-1:0] CNT_MAX = '1;
    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

    logic             s1;
    logic             s2;
    logic             s3;
    logic             rise;
    logic             fall;
    logic             det;
    logic [WIDTH-1:0] count_next;
    logic             overflow_next;

    // s1/s2 form the synchroniser; s3 is history for edge detection only,
    // so mode changes never disturb it and cannot create false edges.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= t_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise = s2 & ~s3;
    assign fall = ~s2 & s3;

    always_comb begin
        det = 1'b0;
        case (mode)
            2'b00:   det = rise;
            2'b01:   det = fall;
            2'b10:   det = rise | fall;
            default: det = 1'b0;
        endcase
    end

    // clear wins over a coincident edge: the edge still strobes but is not counted.
    always_comb begin
        count_next    = count;
        overflow_next = overflow;
        if (clear) begin
            count_next    = '0;
            overflow_next = 1'b0;
        end else if (det && enable) begin
            if (count != CNT_MAX) begin
                count_next = count + CNT_ONE;
            end else begin
                overflow_next = 1'b1;
                if (SATURATE == 0) begin
                    count_next = '0;
                end
            end
        end
    end

    // match is computed from count_next so it lines up with the count register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            edge_pulse <= 1'b0;
            count      <= '0;
            match      <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            edge_pulse <= det;
            count      <= count_next;
            match      <= (count_next == compare);
            overflow   <= overflow_next;
        end
    end

endmodule

// File: tb/tb_t_edge_counter.sv
// tb/tb_t_edge_counter.sv - self-checking bench for t_edge_counter

module tb_t_edge_counter;

    logic       clock = 1'b0;
    logic       reset;
    logic       t_in;
    logic       enable;
    logic       clear;
    logic [1:0] mode;
    logic [7:0] cmp8;
    logic [3:0] cmp4;

    logic       p8, m8, o8;
    logic [7:0] c8;
    logic       p4w, m4w, o4w;
    logic [3:0] c4w;
    logic       p4s, m4s, o4s;
    logic [3:0] c4s;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    t_edge_counter #(.WIDTH(8), .SATURATE(0)) dut8 (
        .clock(clock), .reset(reset), .t_in(t_in), .enable(enable), .clear(clear),
        .mode(mode), .compare(cmp8), .edge_pulse(p8), .count(c8), .match(m8), .overflow(o8)
    );

    t_edge_counter #(.WIDTH(4), .SATURATE(0)) dut4w (
        .clock(clock), .reset(reset), .t_in(t_in), .enable(enable), .clear(clear),
        .mode(mode), .compare(cmp4), .edge_pulse(p4w), .count(c4w), .match(m4w), .overflow(o4w)
    );

    t_edge_counter #(.WIDTH(4), .SATURATE(1)) dut4s (
        .clock(clock), .reset(reset), .t_in(t_in), .enable(enable), .clear(clear),
        .mode(mode), .compare(cmp4), .edge_pulse(p4s), .count(c4s), .match(m4s), .overflow(o4s)
    );

    // Reference model: history of t_in as seen at each clock edge since reset.
    // A change sampled at edge k appears as a strobe after edge k+2.
    bit samp[$];
    int m_cnt[3];
    bit m_ov[3];
    bit m_match[3];
    bit m_pulse;
    int mx[3]  = '{255, 15, 15};
    bit sat[3] = '{1'b0, 1'b0, 1'b1};

    function automatic bit sample_at(int idx);
        if (idx < 0) return 1'b0;
        return samp[idx];
    endfunction

    task automatic model_reset();
        samp.delete();
        m_pulse = 1'b0;
        for (int i = 0; i < 3; i++) begin
            m_cnt[i]   = 0;
            m_ov[i]    = 1'b0;
            m_match[i] = 1'b0;
        end
    endtask

    task automatic model_edge();
        int n;
        bit now_v, old_v, d;
        int nxt, c;
        samp.push_back(t_in);
        n = samp.size() - 1;
        now_v = sample_at(n - 2);
        old_v = sample_at(n - 3);
        case (mode)
            2'b00:   d = now_v && !old_v;
            2'b01:   d = !now_v && old_v;
            2'b10:   d = now_v != old_v;
            default: d = 1'b0;
        endcase
        m_pulse = d;
        for (int i = 0; i < 3; i++) begin
            if (clear) begin
                m_cnt[i] = 0;
                m_ov[i]  = 1'b0;
            end else if (d && enable) begin
                nxt = m_cnt[i] + 1;
                if (nxt > mx[i]) begin
                    m_ov[i]  = 1'b1;
                    m_cnt[i] = sat[i] ? mx[i] : nxt % (mx[i] + 1);
                end else begin
                    m_cnt[i] = nxt;
                end
            end
            c = (i == 0) ? int'(cmp8) : int'(cmp4);
            m_match[i] = (m_cnt[i] == c);
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("w8_pulse", 32'(p8),  32'(m_pulse));
        chk("w8_count", 32'(c8),  32'(m_cnt[0]));
        chk("w8_match", 32'(m8),  32'(m_match[0]));
        chk("w8_ovf",   32'(o8),  32'(m_ov[0]));
        chk("wrap_pulse", 32'(p4w), 32'(m_pulse));
        chk("wrap_count", 32'(c4w), 32'(m_cnt[1]));
        chk("wrap_match", 32'(m4w), 32'(m_match[1]));
        chk("wrap_ovf",   32'(o4w), 32'(m_ov[1]));
        chk("sat_pulse",  32'(p4s), 32'(m_pulse));
        chk("sat_count",  32'(c4s), 32'(m_cnt[2]));
        chk("sat_match",  32'(m4s), 32'(m_match[2]));
        chk("sat_ovf",    32'(o4s), 32'(m_ov[2]));
    endtask

    // One clock: DUT samples on the rising edge, model and checks 1ns later.
    task automatic tick();
        @(posedge clock);
        #1;
        if (!reset) model_reset();
        else        model_edge();
        check_all();
    endtask

    task automatic rises(input int n, input int half);
        for (int i = 0; i < n; i++) begin
            t_in = 1'b1;
            repeat (half) tick();
            t_in = 1'b0;
            repeat (half) tick();
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_p8"}, 32'(p8), 32'd0);
        chk({tag, "_c8"}, 32'(c8), 32'd0);
        chk({tag, "_m8"}, 32'(m8), 32'd0);
        chk({tag, "_o8"}, 32'(o8), 32'd0);
        chk({tag, "_c4w"}, 32'(c4w), 32'd0);
        chk({tag, "_o4w"}, 32'(o4w), 32'd0);
        chk({tag, "_c4s"}, 32'(c4s), 32'd0);
        chk({tag, "_o4s"}, 32'(o4s), 32'd0);
    endtask

    initial begin
        reset  = 1'b1;
        t_in   = 1'b0;
        enable = 1'b1;
        clear  = 1'b0;
        mode   = 2'b00;
        cmp8   = 8'd3;
        cmp4   = 4'd9;
        model_reset();
        #1;
        reset = 1'b0;
        #2;
        check_all_zero("reset_async");
        tick();
        tick();
        reset = 1'b1;

        // first clock after release: match reflects compare==0 (false here)
        tick();

        // 8 rising edges, toggling every 2 clocks; match high only at count 3
        rises(8, 2);
        tick();
        chk("eight_rises_c8", 32'(c8), 32'd8);

        // wrap and saturate at width 4
        rises(9, 2);
        tick();
        chk("wrap17_c4w", 32'(c4w), 32'd1);
        chk("wrap17_o4w", 32'(o4w), 32'd1);
        chk("sat17_c4s",  32'(c4s), 32'd15);
        rises(3, 2);
        tick();
        chk("sat20_c4s", 32'(c4s), 32'd15);
        chk("sat20_o4s", 32'(o4s), 32'd1);
        chk("wrap20_c4w", 32'(c4w), 32'd4);
        chk("w8_20_c8", 32'(c8), 32'd20);

        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clear_c4w", 32'(c4w), 32'd0);
        chk("clear_o4w", 32'(o4w), 32'd0);

        // both-edge mode with t_in toggling every clock
        mode = 2'b10;
        for (int i = 0; i < 12; i++) begin
            t_in = ~t_in;
            tick();
        end
        chk("both_pulse", 32'(p8), 32'd1);

        // detection off
        mode = 2'b11;
        for (int i = 0; i < 8; i++) begin
            t_in = ~t_in;
            tick();
        end
        chk("off_pulse", 32'(p8), 32'd0);

        // enable low: pulses but no counting
        mode   = 2'b00;
        t_in   = 1'b0;
        repeat (4) tick();
        enable = 1'b0;
        rises(4, 2);
        enable = 1'b1;
        repeat (3) tick();

        // clear coincident with a detected edge
        t_in = 1'b1;
        tick();
        tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clr_edge_p8", 32'(p8), 32'd1);
        chk("clr_edge_c8", 32'(c8), 32'd0);
        t_in = 1'b0;
        repeat (4) tick();

        // asynchronous reset at count 5
        rises(5, 2);
        tick();
        chk("pre_reset_c8", 32'(c8), 32'd5);
        t_in = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        check_all_zero("reset_mid");
        tick();
        reset = 1'b1;
        tick();
        tick();
        chk("rel_hi_p8_early", 32'(p8), 32'd0);
        tick();
        chk("rel_hi_p8", 32'(p8), 32'd1);
        chk("rel_hi_c8", 32'(c8), 32'd1);
        tick();

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            t_in   = 1'($urandom);
            enable = ($urandom_range(0, 7) != 0);
            clear  = ($urandom_range(0, 40) == 0);
            if ($urandom_range(0, 15) == 0) mode = 2'($urandom);
            if ($urandom_range(0, 31) == 0) cmp8 = 8'($urandom_range(0, 20));
            if ($urandom_range(0, 31) == 0) cmp4 = 4'($urandom);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
